// File: rtl/laser_pkg.sv
// laser_pkg: shared types and sizes for the laser scan search controller
package laser_pkg;
  localparam int GRID_W = 4;
  localparam int CNT_W = 6;
  localparam int N_POINTS = 40;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;
endpackage

// File: rtl/laser_cand_cnt.sv
// laser_cand_cnt: raster candidate index with clear, increment and last flag
module laser_cand_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] idx,
  output logic         last
);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) idx <= '0;
    else if (clr) idx <= '0;
    else if (inc) idx <= idx + 1'b1;
  assign last = &idx;
endmodule

// File: rtl/laser_scan_ctrl.sv
// laser_scan_ctrl: alternating exhaustive sweep of two circle centers that
// maximises the covered-point count reported by an external datapath
module laser_scan_ctrl
  import laser_pkg::*;
#(
  parameter int MAX_PASS = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              BUSY,
  output logic              EVAL_REQ,
  output logic              EVAL_SEL,
  output logic [GRID_W-1:0] EVAL_CX,
  output logic [GRID_W-1:0] EVAL_CY,
  output logic [GRID_W-1:0] EVAL_OX,
  output logic [GRID_W-1:0] EVAL_OY,
  input  logic              EVAL_ACK,
  input  logic [CNT_W-1:0]  EVAL_CNT,
  output logic [GRID_W-1:0] C1X,
  output logic [GRID_W-1:0] C1Y,
  output logic [GRID_W-1:0] C2X,
  output logic [GRID_W-1:0] C2Y,
  output logic              DONE
);
  state_t state, state_nx;
  logic [2:0] pass;
  logic [CNT_W-1:0] best;
  logic [GRID_W-1:0] w1x, w1y, w2x, w2y, pbx, pby;
  logic [2*GRID_W-1:0] idx;
  logic improved, last, start_ok, ack, better, stop;
  assign start_ok = (state == IDLE) && START;
  assign ack = (state == WAIT) && EVAL_ACK;
  assign better = ack && (EVAL_CNT > best);
  assign stop = (!improved && pass != 3'd0) || pass == 3'(MAX_PASS - 1);
  laser_cand_cnt #(.W(2 * GRID_W)) u_cnt (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clr  (start_ok || state == NEXT),
    .inc  (ack && !last),
    .idx  (idx),
    .last (last)
  );
  assign EVAL_REQ = state == WAIT;
  assign EVAL_SEL = pass[0];
  assign EVAL_CX = idx[GRID_W-1:0];
  assign EVAL_CY = idx[2*GRID_W-1:GRID_W];
  assign EVAL_OX = pass[0] ? w1x : w2x;
  assign EVAL_OY = pass[0] ? w1y : w2y;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (EVAL_ACK) state_nx = last ? NEXT : ISSUE;
      NEXT:    state_nx = stop ? FINISH : ISSUE;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      pass <= '0;
      best <= '0;
      improved <= 1'b0;
      {w1x, w1y, w2x, w2y, pbx, pby} <= '0;
      {C1X, C1Y, C2X, C2Y} <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      state <= state_nx;
      DONE <= 1'b0;
      if (start_ok) begin
        pass <= '0;
        best <= '0;
        improved <= 1'b0;
        {w1x, w1y, w2x, w2y, pbx, pby} <= '0;
        BUSY <= 1'b1;
      end
      if (better) begin
        best <= EVAL_CNT;
        pbx <= idx[GRID_W-1:0];
        pby <= idx[2*GRID_W-1:GRID_W];
        improved <= 1'b1;
      end
      // commit the pass winner and seed the next pass-best with the other circle's center
      if (state == NEXT) begin
        if (pass[0]) begin
          {w2x, w2y} <= {pbx, pby};
          {pbx, pby} <= {w1x, w1y};
        end else begin
          {w1x, w1y} <= {pbx, pby};
          {pbx, pby} <= {w2x, w2y};
        end
        improved <= 1'b0;
        if (!stop) pass <= pass + 1'b1;
      end
      if (state == FINISH) begin
        {C1X, C1Y, C2X, C2Y} <= {w1x, w1y, w2x, w2y};
        BUSY <= 1'b0;
        DONE <= 1'b1;
      end
    end
  end
endmodule

// File: doc/laser_scan_ctrl.md
LASER_SCAN_CTRL -- requirements
Module: laser_scan_ctrl

Interface
REQ-001 SHALL have parameter MAX_PASS, default 4, maximum number of sweep passes (range 2..7).
REQ-002 SHALL have ports, clock and reset first:
  CLK       in   1  clock; all state changes on rising edge.
  RST_N     in   1  asynchronous, active-low reset.
  START     in   1  one-cycle pulse; begins a search when idle.
  BUSY      out  1  high from the cycle after an accepted START until DONE.
  EVAL_REQ  out  1  request to the coverage datapath to evaluate a candidate.
  EVAL_SEL  out  1  0 = candidate is circle 1; 1 = candidate is circle 2.
  EVAL_CX   out  4  candidate center X.
  EVAL_CY   out  4  candidate center Y.
  EVAL_OX   out  4  X of the fixed (other) circle center.
  EVAL_OY   out  4  Y of the fixed (other) circle center.
  EVAL_ACK  in   1  one-cycle pulse; EVAL_CNT is valid in this cycle.
  EVAL_CNT  in   6  points covered by the union of both circles (0..40).
  C1X, C1Y, C2X, C2Y  out  4 each  final centers.
  DONE      out  1  one-cycle pulse when the final centers are valid.

Function
REQ-003 SHALL use FSM states IDLE, ISSUE, WAIT, NEXT, FINISH.
REQ-004 In IDLE, a START SHALL initialise the search and move the FSM to ISSUE:
  - both working centers = (0,0); best count = 0; pass = 0; sweep index = 0.
REQ-005 START SHALL be ignored in every state except IDLE.
REQ-006 Pass p SHALL sweep circle 1 when p is even and circle 2 when p is odd; EVAL_SEL = p[0].
REQ-007 The sweep index SHALL be an 8-bit counter giving EVAL_CX = idx[3:0] and EVAL_CY = idx[7:4], raster order from 0 to 255.
REQ-008 EVAL_OX and EVAL_OY SHALL carry the committed center of the non-swept circle and stay constant for the whole pass.
REQ-009 In ISSUE the block SHALL assert EVAL_REQ and move to WAIT.
REQ-010 EVAL_REQ, EVAL_SEL, EVAL_CX/CY and EVAL_OX/OY SHALL stay stable until EVAL_ACK is sampled high.
REQ-011 EVAL_ACK SHALL be honoured only while EVAL_REQ is high; ACK latency SHALL be unbounded, minimum 1 cycle.
REQ-012 On the ACK cycle:
  - EVAL_REQ falls in the next cycle.
  - if EVAL_CNT > best count (strictly greater), best count and the swept circle's pass-best center take the value and candidate.
  - ties SHALL keep the earlier candidate.
REQ-013 After the ACK:
  - idx != 255: idx increments and the FSM returns to ISSUE, so there is at least one idle REQ-low cycle between requests.
  - idx == 255: the FSM goes to NEXT.
REQ-014 In NEXT:
  - the pass-best center is committed as the swept circle's working center and idx wraps to 0.
  - if the pass improved nothing and p >= 1, or p == MAX_PASS-1, the FSM goes to FINISH.
  - otherwise p increments and the FSM goes to ISSUE.
REQ-015 In FINISH:
  - C1X/C1Y/C2X/C2Y are loaded from the working centers.
  - DONE pulses for exactly one cycle.
  - BUSY falls in the same cycle and the FSM returns to IDLE.
REQ-016 C1X/C1Y/C2X/C2Y SHALL hold their value until the next FINISH or reset.
REQ-017 Each pass SHALL issue exactly 256 requests; total requests = 256 x passes executed.
REQ-018 Best count SHALL be 6 bits, with unsigned comparison.

Reset
REQ-019 RST_N low SHALL asynchronously force:
  - FSM to IDLE.
  - EVAL_REQ, BUSY and DONE to 0.
  - all 4-bit outputs to 0.
  - counters and best count to 0.
REQ-020 Reset mid-search SHALL abort the search with no DONE; an ACK arriving after reset SHALL be ignored.

Structure
REQ-021 Package laser_pkg SHALL hold the FSM state enum, GRID_W=4, CNT_W=6 and N_POINTS=40.
REQ-022 A sub-module laser_cand_cnt (8-bit raster index with clear, increment and last flag) SHALL be instantiated once.

Verification
REQ-023 Reset: assert RST_N=0 mid-operation -> all outputs are 0 within the same cycle and BUSY=0.
REQ-024 Stub returns 30 at C1 candidate (3,4), 38 at C2 candidate (10,10) with other=(3,4), and otherwise <=38 -> DONE with C1=(3,4), C2=(10,10), 768 requests.
REQ-025 Stub always returns 20 -> DONE after 512 requests, C1=C2=(0,0).
REQ-026 Random ACK latency of 1..5 cycles -> REQ and all EVAL_* fields stable until ACK, one REQ-low cycle between requests, results identical to REQ-024.
REQ-027 RST_N pulsed low at request 100, then START -> no DONE from the aborted run, and the first request after restart is (0,0) with SEL=0.
REQ-028 Stub strictly improves every pass, plus START pulses while BUSY -> DONE after exactly 1024 requests (MAX_PASS=4) and the extra STARTs are ignored.
